// File: rtl/sponge_xof_core.sv
// Keccak sponge controller for SHA-3/SHAKE-style XOFs. It pads with pad10*1 and a domain suffix,
// absorbs rate-wide message words and squeezes the requested number of blocks through an external permutation.
module sponge_xof_core #(
    parameter int          RATE_BITS = 1088,
    parameter logic [7:0]  DS        = 8'h1F,
    parameter int          NBLK_W    = 8,
    localparam int         RB        = RATE_BITS / 8,
    localparam int         BW        = $clog2(RATE_BITS / 8 + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RATE_BITS-1:0] in_data,
    input  logic                 in_last,
    input  logic [BW-1:0]        in_bytes,
    input  logic [NBLK_W-1:0]    out_nblocks,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RATE_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 perm_start,
    output logic [1599:0]        perm_state,
    input  logic                 perm_done,
    input  logic [1599:0]        perm_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PERM_A,
        S_PAD,
        S_SQZ,
        S_PERM_S
    } fsm_e;

    localparam logic [NBLK_W-1:0]    ONE_BLK = NBLK_W'(1);
    // This is the extra block absorbed when the final word was completely full.
    localparam logic [RATE_BITS-1:0] PAD_BLK = {8'h80, {(RATE_BITS - 16){1'b0}}, DS};

    fsm_e                 fsm_q;
    logic [1599:0]        state_q;
    logic [NBLK_W-1:0]    blk_left_q;
    logic                 last_q;
    logic                 need_pad_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 busy_q;
    logic                 perm_start_q;
    logic [RATE_BITS-1:0] msg_blk_d;

    // NOTE: every variable driven from always_comb gets a full default first, so no latch can form.
    always_comb begin
        msg_blk_d = in_data;
        if (in_last && int'(in_bytes) < RB) begin
            for (int i = 0; i < RB; i++) begin
                if (i >= int'(in_bytes)) msg_blk_d[8*i +: 8] = 8'h00;
                if (i == int'(in_bytes)) msg_blk_d[8*i +: 8] = msg_blk_d[8*i +: 8] ^ DS;
            end
            msg_blk_d[RATE_BITS-1 -: 8] = msg_blk_d[RATE_BITS-1 -: 8] ^ 8'h80;
        end
    end

    // NOTE: state is non-blocking only, so every branch sees the values from the previous cycle.
    // NOTE: the 1600-bit state is a register file that the reset clears, because an aborted
    //       message must not leak into the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q        <= S_IDLE;
            state_q      <= '0;
            blk_left_q   <= '0;
            last_q       <= 1'b0;
            need_pad_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            perm_start_q <= 1'b0;
        end else begin
            perm_start_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    fsm_q      <= S_ABSORB;
                end
                S_ABSORB: begin
                    if (in_valid && in_ready_q) begin
                        state_q[RATE_BITS-1:0] <= state_q[RATE_BITS-1:0] ^ msg_blk_d;
                        // When busy is still low, this word is the first word of a new message.
                        if (!busy_q) blk_left_q <= (out_nblocks == '0) ? ONE_BLK : out_nblocks;
                        busy_q       <= 1'b1;
                        last_q       <= in_last;
                        need_pad_q   <= in_last && int'(in_bytes) >= RB;
                        in_ready_q   <= 1'b0;
                        perm_start_q <= 1'b1;
                        fsm_q        <= S_PERM_A;
                    end
                end
                S_PERM_A: begin
                    if (perm_done) begin
                        state_q <= perm_result;
                        if (!last_q) begin
                            in_ready_q <= 1'b1;
                            fsm_q      <= S_ABSORB;
                        end else if (need_pad_q) begin
                            fsm_q <= S_PAD;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_last_q  <= (blk_left_q == ONE_BLK);
                            fsm_q       <= S_SQZ;
                        end
                    end
                end
                S_PAD: begin
                    state_q[RATE_BITS-1:0] <= state_q[RATE_BITS-1:0] ^ PAD_BLK;
                    need_pad_q   <= 1'b0;
                    perm_start_q <= 1'b1;
                    fsm_q        <= S_PERM_A;
                end
                S_SQZ: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        blk_left_q  <= blk_left_q - ONE_BLK;
                        if (blk_left_q == ONE_BLK) begin
                            state_q <= '0;
                            busy_q  <= 1'b0;
                            fsm_q   <= S_IDLE;
                        end else begin
                            perm_start_q <= 1'b1;
                            fsm_q        <= S_PERM_S;
                        end
                    end
                end
                S_PERM_S: begin
                    if (perm_done) begin
                        state_q     <= perm_result;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (blk_left_q == ONE_BLK);
                        fsm_q       <= S_SQZ;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = state_q[RATE_BITS-1:0];
    assign busy       = busy_q;
    assign perm_start = perm_start_q;
    assign perm_state = state_q;

endmodule

// File: tb/tb_sponge_xof_core.sv
// Directed bench for sponge_xof_core. It uses an identity permutation stub with a latency of 3 cycles, and every
// expected block is built by hand from the padding rules.
module tb_sponge_xof_core;

    localparam int R  = 1088;
    localparam int RB = R / 8;
    localparam int BW = $clog2(RB + 1);

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, in_last, out_valid, out_ready, out_last, busy;
    logic [R-1:0]    in_data, out_data;
    logic [BW-1:0]   in_bytes;
    logic [7:0]      out_nblocks;
    logic            perm_start, perm_done;
    logic [1599:0]   perm_state, perm_result;
    logic [2:0]      perm_sr;
    int              n_vec = 0;
    int              n_bad = 0;
    int              n_starts = 0;
    bit              overlap = 1'b0;

    always #5 clock = ~clock;

    sponge_xof_core #(.RATE_BITS(R), .DS(8'h1F), .NBLK_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes), .out_nblocks(out_nblocks),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy),
        .perm_start(perm_start), .perm_state(perm_state),
        .perm_done(perm_done), .perm_result(perm_result)
    );

    // The identity permutation is reset together with the core.
    always @(posedge clock or negedge reset)
        if (!reset) perm_sr <= 3'b000;
        else        perm_sr <= {perm_sr[1:0], perm_start};
    assign perm_done   = perm_sr[2];
    assign perm_result = perm_state ^ {1600{1'b0}};

    always @(posedge clock) begin
        if (reset && perm_start) n_starts <= n_starts + 1;
        if (perm_start && |perm_sr) overlap <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [R-1:0] got, input logic [R-1:0] exp);
        for (int i = 0; i < R / 64; i++)
            check($sformatf("%s.lane%0d", tag, i), got[64*i +: 64], exp[64*i +: 64]);
    endtask

    function automatic logic [R-1:0] fill(input logic [7:0] b);
        logic [R-1:0] v;
        for (int i = 0; i < RB; i++) v[8*i +: 8] = b;
        return v;
    endfunction

    task automatic send_word(input logic [R-1:0] d, input bit last, input int nbytes,
                             input int nblk, input string tag);
        int k;
        in_data     = d;
        in_last     = last;
        in_bytes    = BW'(nbytes);
        out_nblocks = 8'(nblk);
        in_valid    = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clock);
            k++;
        end
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv_blk(input logic [R-1:0] exp, input bit exp_last, input string tag);
        int k;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clock);
            k++;
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check_blk(tag, out_data, exp);
        check({tag, ".out_last"}, 64'(out_last), 64'(exp_last));
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [R-1:0] exp1, exp2, exp3, exp4, w2, snap;
        int s0, k;

        exp1 = '0;         exp1[7:0] = 8'h1F;  exp1[R-1 -: 8] = 8'h80;
        exp2 = fill(8'hAA); exp2[R-1 -: 8] = 8'h9F;
        exp3 = fill(8'h55); exp3[7:0] = 8'h4A; exp3[R-1 -: 8] = 8'hD5;
        w2   = fill(8'hFF); w2[7:0] = 8'h34;   w2[15:8] = 8'h12;
        exp4 = fill(8'h3C); exp4[7:0] = 8'h08; exp4[15:8] = 8'h2E; exp4[23:16] = 8'h23;
        exp4[R-1 -: 8] = 8'hBC;

        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = '0;
        out_nblocks = '0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.perm_start", 64'(perm_start), 64'd0);
        check("rst.state", 64'(|perm_state), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("rel.in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);

        // The empty message with N=0 is treated as one block, and the FF data must be masked away.
        s0 = n_starts;
        send_word(fill(8'hFF), 1'b1, 0, 0, "t1");
        check("t1.busy", 64'(busy), 64'd1);
        recv_blk(exp1, 1'b1, "t1");
        check("t1.starts", 64'(n_starts - s0), 64'd1);
        check("t1.busy_end", 64'(busy), 64'd0);

        s0 = n_starts;
        send_word(fill(8'hAA), 1'b1, 135, 1, "t2");
        recv_blk(exp2, 1'b1, "t2");
        check("t2.starts", 64'(n_starts - s0), 64'd1);

        s0 = n_starts;
        send_word(fill(8'h55), 1'b1, 136, 1, "t3");
        recv_blk(exp3, 1'b1, "t3");
        check("t3.starts", 64'(n_starts - s0), 64'd2);

        // Two words and three blocks: out_nblocks on the second word must be ignored.
        s0 = n_starts;
        send_word(fill(8'h3C), 1'b0, 5, 3, "t4w0");
        send_word(w2, 1'b1, 2, 9, "t4w1");
        recv_blk(exp4, 1'b0, "t4b0");
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clock);
            k++;
        end
        snap = out_data;
        check("t5.valid", 64'(out_valid), 64'd1);
        begin
            int s5;
            s5 = n_starts;
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                check($sformatf("t5.hold_valid%0d", i), 64'(out_valid), 64'd1);
                check($sformatf("t5.hold_data%0d", i), 64'(out_data == snap), 64'd1);
            end
            check("t5.no_start", 64'(n_starts - s5), 64'd0);
        end
        recv_blk(exp4, 1'b0, "t4b1");
        recv_blk(exp4, 1'b1, "t4b2");
        check("t4.starts", 64'(n_starts - s0), 64'd4);
        check("t4.busy_end", 64'(busy), 64'd0);
        check("t4.valid_end", 64'(out_valid), 64'd0);
        check("t4.capacity", 64'(|perm_state[1599:R]), 64'd0);

        // Assert reset while the core waits in PERM_A, then run a fresh message.
        send_word(fill(8'h77), 1'b1, 10, 1, "t6");
        reset = 1'b0;
        #1;
        check("t6.in_ready", 64'(in_ready), 64'd0);
        check("t6.out_valid", 64'(out_valid), 64'd0);
        check("t6.out_last", 64'(out_last), 64'd0);
        check("t6.busy", 64'(busy), 64'd0);
        check("t6.perm_start", 64'(perm_start), 64'd0);
        check("t6.state", 64'(|perm_state), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        s0 = n_starts;
        send_word(fill(8'hFF), 1'b1, 0, 1, "t6r");
        recv_blk(exp1, 1'b1, "t6r");
        check("t6r.starts", 64'(n_starts - s0), 64'd1);

        check("perm_overlap", 64'(overlap), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
